// File: rtl/sram_fifo_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_fifo_ctrl_if : producer/consumer valid-ready handshake bundle   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface sram_fifo_ctrl_if #(
  parameter int DATA_W = 128
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DATA_W-1:0] enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [DATA_W-1:0] deq_bits;

  modport master (
    output enq_valid, enq_bits, deq_ready,
    input  enq_ready, deq_valid, deq_bits
  );

  modport slave (
    input  enq_valid, enq_bits, deq_ready,
    output enq_ready, deq_valid, deq_bits
  );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_fifo_ctrl : FIFO controller over a 1R1W SRAM, 2-entry out buf  |
// | Optional macro SRAM_FIFO_CTRL_FLUSH_EN adds a synchronous flush.   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module sram_fifo_ctrl #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic              clock,
  input  wire logic              reset,
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
  input  wire logic              flush,
`endif
  sram_fifo_ctrl_if.slave        fifo,
  output logic [4:0]             count,
  output logic                   sram_web,
  output logic [ADDR_W-1:0]      sram_aa,
  output logic [DATA_W-1:0]      sram_d,
  output logic                   sram_reb,
  output logic [ADDR_W-1:0]      sram_ab,
  input  wire logic [DATA_W-1:0] sram_q
);

  localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_sram_cnt;
  logic              r_rd_inflight;
  logic [1:0]        r_obuf_cnt;
  logic              r_head;
  logic [DATA_W-1:0] r_obuf [2];

  logic              w_flush;
  logic              w_clr;
  logic              w_enq_ready;
  logic              w_enq_fire;
  logic              w_deq_valid;
  logic              w_deq_fire;
  logic              w_rd_issue;
  logic [2:0]        w_occ;
  logic              w_tail;
  logic [ADDR_W-1:0] w_wptr_nxt;
  logic [ADDR_W-1:0] w_rptr_nxt;

`ifdef SRAM_FIFO_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Handshakes are suppressed during reset/flush so no beat is lost silently.
  assign w_clr       = reset | w_flush;
  assign w_enq_ready = !w_clr && (r_sram_cnt < c_DEPTH);
  assign w_enq_fire  = fifo.enq_valid && w_enq_ready;
  assign w_deq_valid = !w_clr && (r_obuf_cnt != 2'd0);
  assign w_deq_fire  = w_deq_valid && fifo.deq_ready;

  // Issue a read only if the output buffer can absorb it after this cycle's pop.
  assign w_occ      = {1'b0, r_obuf_cnt} + {2'b00, r_rd_inflight};
  assign w_rd_issue = !w_clr && (r_sram_cnt != '0) &&
                      (w_occ < (3'd2 + {2'b00, w_deq_fire}));

  assign w_wptr_nxt = (r_wptr == c_LAST) ? '0 : r_wptr + c_PTR_ONE;
  assign w_rptr_nxt = (r_rptr == c_LAST) ? '0 : r_rptr + c_PTR_ONE;
  assign w_tail     = r_head ^ r_obuf_cnt[0];

  assign fifo.enq_ready = w_enq_ready;
  assign fifo.deq_valid = w_deq_valid;
  assign fifo.deq_bits  = r_obuf[r_head];

  assign sram_web = !w_enq_fire;
  assign sram_aa  = r_wptr;
  assign sram_d   = fifo.enq_bits;
  assign sram_reb = !w_rd_issue;
  assign sram_ab  = r_rptr;

  assign count = 5'(r_sram_cnt) + {4'b0000, r_rd_inflight} + {3'b000, r_obuf_cnt};

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_sram_cnt    <= '0;
      r_rd_inflight <= 1'b0;
      r_obuf_cnt    <= 2'd0;
      r_head        <= 1'b0;
    end else begin
      if (w_enq_fire) r_wptr <= w_wptr_nxt;
      if (w_rd_issue) r_rptr <= w_rptr_nxt;
      case ({w_enq_fire, w_rd_issue})
        2'b10:   r_sram_cnt <= r_sram_cnt + c_CNT_ONE;
        2'b01:   r_sram_cnt <= r_sram_cnt - c_CNT_ONE;
        default: r_sram_cnt <= r_sram_cnt;
      endcase
      r_rd_inflight <= w_rd_issue;
      r_obuf_cnt    <= r_obuf_cnt + {1'b0, r_rd_inflight} - {1'b0, w_deq_fire};
      if (w_deq_fire) r_head <= ~r_head;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (r_rd_inflight) r_obuf[w_tail] <= sram_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// Scoreboard bench for sram_fifo_ctrl: driver pushes accepted beats, a monitor pops
// and compares every dequeued beat, SRAM address sequence and occupancy count.
module tb_sram_fifo_ctrl;
  localparam int DW = 128;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush_sig = 1'b0;
  logic [4:0]    count;
  logic          sram_web, sram_reb;
  logic [3:0]    sram_aa, sram_ab;
  logic [DW-1:0] sram_d, sram_q;
  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;
  int npop   = 0;
  logic [DW-1:0] sb [$];

  sram_fifo_ctrl_if #(.DATA_W(DW)) bus ();

  sram_fifo_ctrl #(.DATA_W(DW), .DEPTH(16), .ADDR_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
    .flush    (flush_sig),
`endif
    .fifo     (bus),
    .count    (count),
    .sram_web (sram_web),
    .sram_aa  (sram_aa),
    .sram_d   (sram_d),
    .sram_reb (sram_reb),
    .sram_ab  (sram_ab),
    .sram_q   (sram_q)
  );

  always #5 clock = ~clock;

  // SRAM model: registered read, garbage on cycles without a read.
  always @(posedge clock) begin
    if (!sram_web) mem[sram_aa] <= sram_d;
    if (!sram_reb) sram_q <= mem[sram_ab];
    else           sram_q <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    logic [3:0]    ewa, era;
    int            m_cnt;
    logic [DW-1:0] e;
    ewa = '0; era = '0; m_cnt = 0;
    forever begin
      @(negedge clock);
      if (reset || flush_sig) begin
        chk("clr_web", DW'(sram_web), DW'(1));
        chk("clr_reb", DW'(sram_reb), DW'(1));
        sb.delete();
        m_cnt = 0; ewa = '0; era = '0;
      end else begin
        chk("count", DW'(count), DW'(m_cnt));
        if (!sram_web) begin chk("sram_aa", DW'(sram_aa), DW'(ewa)); ewa = ewa + 4'd1; end
        if (!sram_reb) begin chk("sram_ab", DW'(sram_ab), DW'(era)); era = era + 4'd1; end
        if (bus.deq_valid && bus.deq_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL deq_unexpected actual=%0h required=none", bus.deq_bits);
          end else begin
            e = sb.pop_front();
            chk("deq_bits", bus.deq_bits, e);
          end
          npop++;
          m_cnt--;
        end
        if (bus.enq_valid && bus.enq_ready) m_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic drive_enq(input logic [DW-1:0] v, output bit acc);
    bus.enq_valid = 1'b1;
    bus.enq_bits  = v;
    @(negedge clock);
    acc = bus.enq_ready;
    if (acc) sb.push_back(v);
    step();
    bus.enq_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int nacc, first_rej, gaps, rej, p0;
    logic [DW-1:0] nxt;
    bus.enq_valid = 1'b0; bus.enq_bits = '0; bus.deq_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_deq_valid", DW'(bus.deq_valid), DW'(0));
    chk("rst_enq_ready", DW'(bus.enq_ready), DW'(1));
    step();

    // Single beat latency
    bus.deq_ready = 1'b1; bus.enq_valid = 1'b1; bus.enq_bits = {16{8'hA5}};
    @(negedge clock);
    if (bus.enq_ready) sb.push_back({16{8'hA5}});
    chk("c0_web", DW'(sram_web), DW'(0));
    chk("c0_aa", DW'(sram_aa), DW'(0));
    step(); bus.enq_valid = 1'b0;
    @(negedge clock);
    chk("c1_reb", DW'(sram_reb), DW'(0));
    chk("c1_ab", DW'(sram_ab), DW'(0));
    step();
    @(negedge clock);
    chk("c2_deq_valid", DW'(bus.deq_valid), DW'(0));
    step();
    @(negedge clock);
    chk("c3_deq_valid", DW'(bus.deq_valid), DW'(1));
    chk("c3_deq_bits", bus.deq_bits, {16{8'hA5}});
    step();
    @(negedge clock);
    chk("c4_count", DW'(count), DW'(0));
    step();

    // Fill to capacity with consumer stalled
    bus.deq_ready = 1'b0; nacc = 0; first_rej = -1;
    for (int i = 0; i < 20; i++) begin
      drive_enq(DW'(i), acc);
      if (acc) nacc++;
      else if (first_rej < 0) first_rej = i;
    end
    chk("fill_accepted", DW'(nacc), DW'(18));
    chk("fill_first_reject", DW'(first_rej), DW'(18));
    repeat (2) step();
    @(negedge clock);
    chk("fill_count", DW'(count), DW'(18));
    step();
    p0 = npop;
    bus.deq_ready = 1'b1;
    repeat (18) step();
    @(negedge clock);
    chk("drain_count", DW'(count), DW'(0));
    chk("drain_pops", DW'(npop - p0), DW'(18));
    step();

    // Streaming with wrap-around
    gaps = 0; rej = 0;
    for (int i = 0; i < 100; i++) begin
      bus.enq_valid = 1'b1; bus.enq_bits = DW'(1000 + i);
      @(negedge clock);
      if (bus.enq_ready) sb.push_back(DW'(1000 + i)); else rej++;
      if (i >= 3 && !bus.deq_valid) gaps++;
      step();
    end
    bus.enq_valid = 1'b0;
    chk("stream_gaps", DW'(gaps), DW'(0));
    chk("stream_rejects", DW'(rej), DW'(0));
    repeat (5) step();
    @(negedge clock);
    chk("stream_count", DW'(count), DW'(0));
    step();

    // Random producer/consumer
    nxt = DW'(5000);
    for (int i = 0; i < 300; i++) begin
      bus.enq_valid = ($urandom_range(0, 2) != 0);
      bus.deq_ready = ($urandom_range(0, 2) == 0);
      bus.enq_bits  = nxt;
      @(negedge clock);
      if (bus.enq_valid && bus.enq_ready) begin sb.push_back(nxt); nxt = nxt + DW'(1); end
      step();
    end
    bus.enq_valid = 1'b0; bus.deq_ready = 1'b1;
    repeat (25) step();
    @(negedge clock);
    chk("rand_count", DW'(count), DW'(0));
    chk("rand_sb_empty", DW'(sb.size()), DW'(0));
    step();

    // Reset with a read in flight
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) drive_enq(DW'(200 + i), acc);
    repeat (4) step();
    bus.deq_ready = 1'b1; bus.enq_valid = 1'b1; bus.enq_bits = DW'(300);
    @(negedge clock);
    if (bus.enq_ready) sb.push_back(DW'(300));
    chk("pre_rst_reb", DW'(sram_reb), DW'(0));
    step();
    bus.deq_ready = 1'b0; bus.enq_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_count", DW'(count), DW'(10));
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_count", DW'(count), DW'(0));
    chk("post_rst_deq_valid", DW'(bus.deq_valid), DW'(0));
    step();
    p0 = npop;
    drive_enq(DW'(1), acc);
    bus.deq_ready = 1'b1;
    repeat (5) step();
    chk("post_rst_pops", DW'(npop - p0), DW'(1));

`ifdef SRAM_FIFO_CTRL_FLUSH_EN
    bus.deq_ready = 1'b0;
    for (int i = 0; i < 7; i++) drive_enq(DW'(400 + i), acc);
    repeat (4) step();
    flush_sig = 1'b1; bus.enq_valid = 1'b1; bus.enq_bits = DW'(999);
    @(negedge clock);
    chk("fl_count_before", DW'(count), DW'(7));
    chk("fl_enq_ready", DW'(bus.enq_ready), DW'(0));
    chk("fl_deq_valid", DW'(bus.deq_valid), DW'(0));
    step();
    flush_sig = 1'b0; bus.enq_valid = 1'b0;
    @(negedge clock);
    chk("fl_count_after", DW'(count), DW'(0));
    step();
    p0 = npop;
    drive_enq(DW'(77), acc);
    bus.deq_ready = 1'b1;
    repeat (5) step();
    chk("fl_post_pops", DW'(npop - p0), DW'(1));
`endif

    chk("final_sb_empty", DW'(sb.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameters: DATA_W, default 128, payload width; DEPTH, default 16, SRAM word count; ADDR_W, default 4, SRAM address width (log2 DEPTH).
REQ-002 The block SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports enq_valid (input, 1), enq_ready (output, 1) and enq_bits (input, DATA_W): producer valid/ready handshake.
REQ-005 The block SHALL have ports deq_valid (output, 1), deq_ready (input, 1) and deq_bits (output, DATA_W): consumer valid/ready handshake.
REQ-006 The block SHALL have port count, output, 5, total entries held (SRAM + in-flight read + output buffer), range 0..18.
REQ-007 The block SHALL have the following SRAM write-port outputs: sram_web (output, 1), active-low write enable; sram_aa (output, ADDR_W), write address; sram_d (output, DATA_W), write data.
REQ-008 The block SHALL have the following SRAM read-port signals: sram_reb (output, 1), active-low read enable; sram_ab (output, ADDR_W), read address; sram_q (input, DATA_W), read data, registered in the macro, valid only in the cycle after a read with sram_reb low, garbage otherwise.

Function
REQ-009 The block SHALL operate as a strict-order FIFO; a fire is valid&&ready on the same edge.
REQ-010 enq_ready SHALL equal (sram_cnt < DEPTH); on enq fire: sram_web=0, sram_aa=wptr, sram_d=enq_bits; wptr increments mod DEPTH and sram_cnt increments.
REQ-011 A read SHALL be issued (sram_reb=0, sram_ab=rptr) when sram_cnt>0 && (obuf_cnt + rd_inflight - deq_fire) < 2; rptr increments mod DEPTH and sram_cnt decrements; rd_inflight is set for the next cycle.
REQ-012 sram_cnt SHALL be registered; a word written on edge t SHALL NOT be read before cycle t+1, so no same-cycle read/write of one address occurs.
REQ-013 When rd_inflight=1, sram_q SHALL be captured into the 2-entry output buffer (obuf) at the end of that cycle; sram_q SHALL be ignored in every other cycle.
REQ-014 deq_valid SHALL equal (obuf_cnt > 0), and deq_bits SHALL be the obuf head; deq fire pops the head.
REQ-015 Latency SHALL be 3 cycles from enq fire (edge t) to deq_valid on an empty FIFO; with deq_ready held high, sustained throughput SHALL be 1 entry per cycle.
REQ-016 When enq fire and read issue occur in the same cycle, sram_cnt SHALL be unchanged.
REQ-017 Simultaneous capture and deq fire SHALL leave obuf_cnt unchanged.
REQ-018 count SHALL equal sram_cnt + rd_inflight + obuf_cnt at all times.
REQ-019 When idle, sram_web=1 and sram_reb=1 SHALL hold, and sram_d SHALL follow enq_bits.

Reset
REQ-020 While reset is high on an edge: wptr=0, rptr=0, sram_cnt=0, rd_inflight=0, obuf_cnt=0, giving count=0, deq_valid=0, enq_ready=1 after reset.
REQ-021 sram_web and sram_reb SHALL be 1 in every cycle reset is high.
REQ-022 Reset mid-operation SHALL discard all contents, including an in-flight read.
REQ-023 SRAM contents SHALL NOT be cleared by reset.

Configuration
REQ-024 With macro SRAM_FIFO_CTRL_FLUSH_EN defined, the block SHALL have input port flush, 1 bit.
REQ-025 With SRAM_FIFO_CTRL_FLUSH_EN defined, flush high on an edge SHALL have the same effect on internal state as reset.
REQ-026 With SRAM_FIFO_CTRL_FLUSH_EN defined, in a cycle with flush high, enq_ready=0, deq_valid=0, sram_web=1 and sram_reb=1.
REQ-027 With SRAM_FIFO_CTRL_FLUSH_EN defined, flush SHALL have priority over enq/deq in the same cycle.
REQ-028 Without SRAM_FIFO_CTRL_FLUSH_EN, the flush port SHALL be absent and the logic identical with flush tied 0.

Verification
REQ-029 Reset, then enq 0xA5..A5 at cycle 0 with deq_ready=1 -> sram_web=0 with aa=0 at cycle 0, sram_reb=0 with ab=0 at cycle 1, deq_valid=1 with deq_bits=0xA5..A5 at cycle 3, count returns to 0 at cycle 4.
REQ-030 deq_ready=0, enq 20 beats (values 0..19) -> 18 accepted, enq_ready low from the 19th attempt, count=18; then deq_ready=1 -> outputs 0..17 in order, 1 per cycle.
REQ-031 Continuous enq and deq of an incrementing pattern for 100 cycles -> no gaps after the initial 3-cycle fill; sram_aa and sram_ab wrap 15->0 correctly.
REQ-032 Random deq_ready toggling -> no sram_q capture in cycles without a read in the prior cycle, obuf never exceeds 2, and order is preserved.
REQ-033 Reset asserted while rd_inflight=1 with count=10 -> next cycle count=0 and deq_valid=0; a subsequent enq of 0x1 emerges as the first output.
REQ-034 With SRAM_FIFO_CTRL_FLUSH_EN: flush with count=7 plus simultaneous enq_valid -> enq not accepted, count=0 next cycle.
